// File: rtl/vga_frame_regfile_if.sv
// PicoBlaze port-mapped I/O bus: port address, write data, strobes and read data.
// The master side is the processor and the slave side is the peripheral.
interface vga_frame_regfile_if;
  logic [7:0] Port_ID;
  logic [7:0] IN_DATA;
  logic       Write_Strobe;
  logic       Read_Strobe;
  logic [7:0] OUT_DATA;

  modport master (
    output Port_ID,
    output IN_DATA,
    output Write_Strobe,
    output Read_Strobe,
    input  OUT_DATA
  );

  modport slave (
    input  Port_ID,
    input  IN_DATA,
    input  Write_Strobe,
    input  Read_Strobe,
    output OUT_DATA
  );
endinterface

// File: rtl/vga_frame_regfile.sv
// Double-buffered VGA pointer/sprite register file: software fills the shadow bank, which is copied to the active bank at vsync start.
// Define VGA_REGFILE_READBACK_EN to allow shadow and control read-back through the bus.
module vga_frame_regfile #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int BASE_PORT   = 40,
  parameter int STATUS_PORT = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  vga_frame_regfile_if.slave bus,
  input  logic              VSync,
  input  logic              Blank,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [7:0]        RdData,
  output logic              CommitPending
);

  localparam logic [7:0]        P_ADDR   = 8'(BASE_PORT);
  localparam logic [7:0]        P_DATA   = 8'(BASE_PORT + 1);
  localparam logic [7:0]        P_CTRL   = 8'(BASE_PORT + 2);
  localparam logic [7:0]        P_STATUS = 8'(STATUS_PORT);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  logic [7:0]        r_shadow [DEPTH];
  logic [7:0]        r_active [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic              r_autoinc;
  logic              r_pending;
  logic              r_wrap;
  logic [7:0]        r_rd_data;
  logic              r_vsync_d;

  logic w_wr_addr;
  logic w_wr_data;
  logic w_wr_ctrl;
  logic w_rd_status;
  logic w_rb_inc;
  logic w_inc;
  logic w_vs_start;
  logic w_commit;
  logic w_unused;

  // Blank is reserved for a future status field and has no effect yet.
  assign w_unused = Blank;

  assign w_wr_addr   = bus.Write_Strobe && (bus.Port_ID == P_ADDR);
  assign w_wr_data   = bus.Write_Strobe && (bus.Port_ID == P_DATA);
  assign w_wr_ctrl   = bus.Write_Strobe && (bus.Port_ID == P_CTRL);
  assign w_rd_status = bus.Read_Strobe  && (bus.Port_ID == P_STATUS);

`ifdef VGA_REGFILE_READBACK_EN
  localparam logic [7:0] P_RDBK = 8'(BASE_PORT + 3);

  logic w_rd_ctrl;
  logic w_rd_rdbk;

  assign w_rd_ctrl = bus.Read_Strobe && (bus.Port_ID == P_CTRL);
  assign w_rd_rdbk = bus.Read_Strobe && (bus.Port_ID == P_RDBK);
  assign w_rb_inc  = w_rd_rdbk && r_autoinc;
`else
  assign w_rb_inc  = 1'b0;
`endif

  // An explicit address write in the same cycle overrides any auto-increment.
  assign w_inc      = ((w_wr_data && r_autoinc) || w_rb_inc) && !w_wr_addr;
  assign w_vs_start = r_vsync_d && !VSync;
  assign w_commit   = w_vs_start && r_pending;

  // NOTE: sequential state uses non-blocking assignments, so the commit copy
  // sees the shadow bank as it was before any write landing on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      // NOTE: both banks are reset explicitly because the pixel pipeline must
      // never show stale contents; this rules out block-RAM inference here.
      for (int i = 0; i < DEPTH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_addr    <= '0;
      r_autoinc <= 1'b0;
      r_pending <= 1'b0;
      r_wrap    <= 1'b0;
      r_rd_data <= '0;
      r_vsync_d <= 1'b1;
    end else begin
      r_vsync_d <= VSync;
      r_rd_data <= r_active[RdAddr];

      if (w_commit) begin
        r_active <= r_shadow;
      end

      if (w_wr_data) begin
        r_shadow[r_addr] <= bus.IN_DATA;
      end

      if (w_wr_addr) begin
        r_addr <= bus.IN_DATA[ADDR_W-1:0];
      end else if (w_inc) begin
        r_addr <= r_addr + 1'b1;
      end

      if (w_wr_ctrl) begin
        r_autoinc <= bus.IN_DATA[1];
      end

      // A fresh request wins over the clear, deferring its copy to the next frame.
      if (w_wr_ctrl && bus.IN_DATA[0]) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end

      if (w_inc && (r_addr == TOP_ADDR)) begin
        r_wrap <= 1'b1;
      end else if (w_rd_status) begin
        r_wrap <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    bus.OUT_DATA = 8'h00;
    if (w_rd_status) begin
      bus.OUT_DATA = {5'd0, r_wrap, r_pending, ~VSync};
    end
`ifdef VGA_REGFILE_READBACK_EN
    else if (w_rd_ctrl) begin
      bus.OUT_DATA = {6'd0, r_autoinc, 1'b0};
    end else if (w_rd_rdbk) begin
      bus.OUT_DATA = r_shadow[r_addr];
    end
`endif
  end

  assign RdData        = r_rd_data;
  assign CommitPending = r_pending;

endmodule

// File: tb/tb_vga_frame_regfile.sv
// Directed bench for vga_frame_regfile: reset, commit timing, auto-increment wrap, simultaneous events, read-back.
// Expectations follow VGA_REGFILE_READBACK_EN when the bench is built with it.
module tb_vga_frame_regfile;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic       blank;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       commit_pending;

  int total = 0;
  int bad   = 0;

  vga_frame_regfile_if bus ();

  vga_frame_regfile dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .bus           (bus),
    .VSync         (vsync),
    .Blank         (blank),
    .RdAddr        (rd_addr),
    .RdData        (rd_data),
    .CommitPending (commit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge with strobes low.
  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    bus.Port_ID      = port;
    bus.IN_DATA      = data;
    bus.Write_Strobe = 1'b1;
    @(negedge clk);
    bus.Write_Strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data);
    bus.Port_ID     = port;
    bus.Read_Strobe = 1'b1;
    #1;
    data = bus.OUT_DATA;
    @(negedge clk);
    bus.Read_Strobe = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [3:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    @(negedge clk);
    check(name, rd_data, exp);
  endtask

  task automatic vsync_fall();
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic vsync_rise();
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_vec_t    vecs [6];
    logic [7:0] r;
    logic [7:0] r2;

    vecs[0] = '{4'd0,  8'h3C};
    vecs[1] = '{4'd1,  8'h81};
    vecs[2] = '{4'd2,  8'h42};
    vecs[3] = '{4'd3,  8'h99};
    vecs[4] = '{4'd9,  8'hFE};
    vecs[5] = '{4'd12, 8'h07};

    bus.Port_ID      = 8'h00;
    bus.IN_DATA      = 8'h00;
    bus.Write_Strobe = 1'b0;
    bus.Read_Strobe  = 1'b0;
    vsync   = 1'b1;
    blank   = 1'b0;
    rd_addr = 4'd0;
    rst_n   = 1'b1;
    @(negedge clk);

    // Reset state
    do_reset();
    #1;
    check("reset_out_data", bus.OUT_DATA, 8'h00);
    check("reset_pending", {7'd0, commit_pending}, 8'h00);
    for (int i = 0; i < 16; i++) check_rd($sformatf("reset_rd%0d", i), 4'(i), 8'h00);
    io_read(8'd2, r);
    check("reset_status", r, 8'h00);

    // Basic commit timing
    rd_addr = 4'd3;
    io_write(8'd40, 8'h03);
    io_write(8'd41, 8'hA5);
    @(negedge clk);
    check("precommit_rd", rd_data, 8'h00);
    io_write(8'd42, 8'h01);
    check("req_pending", {7'd0, commit_pending}, 8'h01);
    io_read(8'd2, r);
    check("status_pending", r, 8'h02);
    vsync_fall();
    check("commit_pending_clr", {7'd0, commit_pending}, 8'h00);
    check("commit_rd_latency", rd_data, 8'h00);
    @(negedge clk);
    check("commit_rd_new", rd_data, 8'hA5);
    io_read(8'd2, r);
    check("status_vsync_low", r, 8'h01);
    vsync_rise();

    // Table-driven shadow writes (upper address bits ignored), one commit, readout
    foreach (vecs[i]) begin
      io_write(8'd40, {4'hF, vecs[i].addr});
      io_write(8'd41, vecs[i].data);
    end
    io_write(8'd50, 8'hDE);
    io_write(8'd42, 8'h01);
    vsync_fall();
    vsync_rise();
    foreach (vecs[i]) check_rd($sformatf("table_rd%0d", vecs[i].addr), vecs[i].addr, vecs[i].data);

    // Auto-increment across the top entry
    io_write(8'd42, 8'h02);
    io_write(8'd40, 8'd14);
    io_write(8'd41, 8'h11);
    io_write(8'd41, 8'h22);
    io_write(8'd41, 8'h33);
    io_read(8'd2, r);
    check("status_wrap", r, 8'h04);
    io_read(8'd2, r);
    check("status_wrap_clr", r, 8'h00);
    io_write(8'd42, 8'h03);
    vsync_fall();
    vsync_rise();
    check_rd("autoinc_rd14", 4'd14, 8'h11);
    check_rd("autoinc_rd15", 4'd15, 8'h22);
    check_rd("autoinc_rd0", 4'd0, 8'h33);

    // Commit request in the vs_start cycle defers the copy
    io_write(8'd40, 8'd7);
    io_write(8'd41, 8'h5A);
    bus.Port_ID = 8'd42;
    bus.IN_DATA = 8'h03;
    bus.Write_Strobe = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    bus.Write_Strobe = 1'b0;
    check("late_req_pending", {7'd0, commit_pending}, 8'h01);
    check_rd("late_req_nocopy", 4'd7, 8'h00);
    vsync_rise();
    vsync_fall();
    check("late_req_cleared", {7'd0, commit_pending}, 8'h00);
    check_rd("late_req_copy", 4'd7, 8'h5A);
    vsync_rise();

    // Shadow write in the commit cycle uses the pre-write value
    io_write(8'd40, 8'd5);
    io_write(8'd41, 8'h10);
    io_write(8'd42, 8'h03);
    vsync_fall();
    vsync_rise();
    io_write(8'd40, 8'd5);
    io_write(8'd42, 8'h03);
    bus.Port_ID = 8'd41;
    bus.IN_DATA = 8'h77;
    bus.Write_Strobe = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    bus.Write_Strobe = 1'b0;
    check("wr_commit_pending", {7'd0, commit_pending}, 8'h00);
    check_rd("wr_commit_old", 4'd5, 8'h10);
    vsync_rise();
    io_write(8'd42, 8'h03);
    vsync_fall();
    check_rd("wr_commit_next", 4'd5, 8'h77);
    vsync_rise();

    // Two requests give exactly one copy
    io_write(8'd42, 8'h01);
    io_write(8'd40, 8'd9);
    io_write(8'd41, 8'h55);
    io_write(8'd42, 8'h01);
    vsync_fall();
    check_rd("double_req_copy", 4'd9, 8'h55);
    vsync_rise();
    io_write(8'd40, 8'd9);
    io_write(8'd41, 8'h66);
    vsync_fall();
    check("double_req_idle", {7'd0, commit_pending}, 8'h00);
    check_rd("double_req_once", 4'd9, 8'h55);
    vsync_rise();

    // Read-back path
    io_write(8'd42, 8'h02);
    io_write(8'd40, 8'd2);
    io_read(8'd43, r);
    io_read(8'd43, r2);
`ifdef VGA_REGFILE_READBACK_EN
    check("rdbk_first", r, 8'h42);
    check("rdbk_second", r2, 8'h99);
`else
    check("rdbk_first", r, 8'h00);
    check("rdbk_second", r2, 8'h00);
`endif
    io_read(8'd42, r);
`ifdef VGA_REGFILE_READBACK_EN
    check("rdbk_ctrl", r, 8'h02);
`else
    check("rdbk_ctrl", r, 8'h00);
`endif
    io_write(8'd41, 8'hBB);
    io_write(8'd42, 8'h03);
    vsync_fall();
    vsync_rise();
`ifdef VGA_REGFILE_READBACK_EN
    check_rd("rdbk_addr2", 4'd2, 8'h42);
    check_rd("rdbk_addr4", 4'd4, 8'hBB);
`else
    check_rd("rdbk_addr2", 4'd2, 8'hBB);
    check_rd("rdbk_addr4", 4'd4, 8'h00);
`endif

    // Reset while a commit is pending
    io_write(8'd40, 8'd1);
    io_write(8'd41, 8'hEE);
    io_write(8'd42, 8'h03);
    check("pre_reset_pending", {7'd0, commit_pending}, 8'h01);
    do_reset();
    check("post_reset_pending", {7'd0, commit_pending}, 8'h00);
    check_rd("post_reset_rd0", 4'd0, 8'h00);
    check_rd("post_reset_rd1", 4'd1, 8'h00);
    vsync_fall();
    check_rd("post_reset_nocopy", 4'd1, 8'h00);
    io_read(8'd2, r);
    check("post_reset_status", r, 8'h01);
    vsync_rise();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
